// File: rtl/enc_n_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared types, policy constants and helpers for enc_n_rr.
//  Revision    : 1.0  initial release
// ============================================================================
package enc_pkg;

    localparam int RR_FIXED = 0;
    localparam int RR_ROUND = 1;

    // EMPTY: nothing held; FULL: a result awaits acceptance downstream
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } enc_state_t;

    // True when more than one bit is set; clearing the lowest set bit
    // leaves a non-zero value exactly in that case.
    function automatic logic multi_set(input logic [255:0] v);
        return (v & (v - 256'd1)) != 256'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_n_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : enc_n_rr_if
//  Description : Request/result handshake bundle between a requester group
//                and the enc_n_rr encoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface enc_n_rr_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) ();
    logic [N-1:0] req_i;
    logic         en_i;
    logic         ready_i;
    logic [W-1:0] code_o;
    logic         valid_o;
    logic         multi_o;

    // Upstream/downstream side: drives requests and ready, observes results
    modport master (
        output req_i, en_i, ready_i,
        input  code_o, valid_o, multi_o
    );

    // Encoder side
    modport slave (
        input  req_i, en_i, ready_i,
        output code_o, valid_o, multi_o
    );
endinterface
`default_nettype wire

// File: rtl/enc_n_rr_prio_lsb.sv
`default_nettype none
// ============================================================================
//  Module      : enc_prio_lsb
//  Description : Combinational lowest-set-index encoder with an any-set flag.
//  Revision    : 1.0  initial release
// ============================================================================
module enc_prio_lsb #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  wire logic [N-1:0] vec,
    output logic      [W-1:0] idx,
    output logic              any
);

    // Scan from the top down so the lowest set bit is the last to write idx
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (vec[k]) begin
                idx = W'(k);
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/enc_n_rr.sv
`default_nettype none
// ============================================================================
//  Module      : enc_n_rr
//  Description : N-to-log2(N) request encoder with registered result,
//                valid/ready handshake and fixed-priority or round-robin
//                arbitration.
//  Revision    : 1.0  initial release
// ============================================================================
module enc_n_rr
    import enc_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = $clog2(N),
    parameter int RR = RR_FIXED
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    enc_n_rr_if.slave    bus
);

    enc_state_t   r_state;
    enc_state_t   w_state_nxt;
    logic [W-1:0] r_code;
    logic         r_multi;
    logic [W-1:0] w_win;
    logic         w_any;
    logic         w_load;

    // A new result is captured when something is requested and the output
    // slot is free or is being emptied in this same cycle.
    assign w_load = bus.en_i & w_any & ((r_state == ST_EMPTY) | bus.ready_i);

    if (RR == RR_ROUND) begin : g_rr
        logic [W-1:0] r_ptr;
        logic [N-1:0] w_mask;
        logic [N-1:0] w_req_masked;
        logic [W-1:0] w_idx_masked;
        logic         w_any_masked;
        logic [W-1:0] w_idx_all;

        // Keep only requests at or above the pointer
        for (genvar k = 0; k < N; k++) begin : g_mask
            assign w_mask[k] = (k >= int'(r_ptr));
        end
        assign w_req_masked = bus.req_i & w_mask;

        enc_prio_lsb #(.N(N), .W(W)) u_prio_masked (
            .vec (w_req_masked),
            .idx (w_idx_masked),
            .any (w_any_masked)
        );

        enc_prio_lsb #(.N(N), .W(W)) u_prio_all (
            .vec (bus.req_i),
            .idx (w_idx_all),
            .any (w_any)
        );

        // Nothing at/above the pointer means wrap to the lowest request
        assign w_win = w_any_masked ? w_idx_masked : w_idx_all;

        // Advance the pointer past the winner, wrapping at N-1 so it never
        // reaches N even when N is not a power of two
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ptr <= '0;
            end else if (w_load) begin
                r_ptr <= (w_win == W'(N - 1)) ? '0 : w_win + W'(1);
            end
        end
    end else begin : g_fixed
        enc_prio_lsb #(.N(N), .W(W)) u_prio_all (
            .vec (bus.req_i),
            .idx (w_win),
            .any (w_any)
        );
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: fill on load, drain on accept unless refilled in place
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_load)            w_state_nxt = ST_FULL;
                else if (bus.ready_i)  w_state_nxt = ST_EMPTY;
            end
            default:                   w_state_nxt = ST_EMPTY;
        endcase
    end

    // Result registers change only on load, so they hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code  <= '0;
            r_multi <= 1'b0;
        end else if (w_load) begin
            r_code  <= w_win;
            r_multi <= multi_set(256'(bus.req_i));
        end
    end

    assign bus.code_o  = r_code;
    assign bus.multi_o = r_multi;
    assign bus.valid_o = (r_state == ST_FULL);

endmodule
`default_nettype wire

// File: doc/enc_n_rr.md
# enc_n_rr

Parametrised N-to-log2(N) request encoder. It has a registered output, a valid/ready handshake and a selectable fixed-priority or round-robin policy. It replaces hand-written fixed-width encoders in datapaths where several requesters share a single index-consuming stage. The block holds the encoded index stable until downstream accepts it, and flags when more than one request was present.

## Interface
Parameters:
- N, 8, number of request inputs; legal range 2..256, need not be a power of two
- W, $clog2(N), width of the encoded index; derived, do not override
- RR, 0, policy: 0 = fixed priority (lowest index wins), 1 = round robin

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_i  input  N  request vector; bit k requests index k
- en_i  input  1  sample enable; req_i is considered only when en_i=1
- ready_i  input  1  downstream accepts code_o when valid_o=1 and ready_i=1
- code_o  output  W  encoded index of the granted request
- valid_o  output  1  code_o/multi_o hold a result not yet accepted
- multi_o  output  1  more than one req_i bit was set at the capture cycle

## Operation
- Reset values:
  - code_o=0, valid_o=0, multi_o=0
  - internal pointer ptr=0
  - FSM state=EMPTY
- FSM states:
  - EMPTY (valid_o=0)
  - FULL (valid_o=1)
- Load condition: load = en_i & |req_i & (state==EMPTY | ready_i).
- Transitions:
  - EMPTY→FULL on load.
  - FULL→EMPTY on ready_i & ~load.
  - FULL→FULL on ready_i & load (back-to-back, no bubble).
  - FULL holds otherwise.
- Fixed mode: winner = lowest set index of req_i. A one-hot input bit k yields code k; e.g. N=4: 0001→0, 0010→1, 0100→2, 1000→3.
- Round-robin mode:
  - winner = lowest set index ≥ ptr; if none, the lowest set index overall (wrap).
  - On load, ptr ← winner+1, or 0 when winner=N-1. This also holds for non-power-of-two N: ptr never reaches N.
- Fixed mode never updates ptr.
- On load: code_o←winner, multi_o←(popcount(req_i)>1).
- req_i=0 or en_i=0: no load, ptr unchanged. A FULL entry still drains on ready_i.
- Hold rule: while valid_o=1 & ready_i=0, code_o and multi_o are stable regardless of req_i/en_i.
- Requests are not latched: a request deasserted before it is sampled is lost.

## Timing
- Latency: req_i sampled at edge t appears on code_o/valid_o after edge t (1 cycle).
- Throughput: one result per cycle with ready_i held high.
- ready_i to load path is combinational (ready_i gates load in the same cycle). There is no combinational path from req_i to outputs.
- rst_n assertion clears all outputs and ptr immediately, without a clock edge, including mid-FULL. Deassertion is synchronised externally; the first load is possible at the first edge after deassertion.
- ready_i while EMPTY is ignored.

## Structure
- Shared package enc_pkg:
  - popcount-greater-than-one function
  - RR_FIXED / RR_ROUND constants
- Sub-module enc_prio_lsb (combinational, param N): lowest-set-index encoder with an any-set flag.
  - Instantiated twice in RR mode: on req_i & mask(ptr) and on req_i.
  - Masked result is preferred when its any-set flag is 1.
  - Fixed mode uses only the unmasked instance.
- Top: FSM, ptr register, output registers.

## Test plan
- Reset: rst_n=0 with req_i=0xFF, en_i=1 → code_o=0, valid_o=0, multi_o=0. After release with req_i=0, valid_o stays 0 for 10 cycles.
- Fixed, N=4, ready_i=1:
  - req_i=0100 → next cycle code_o=2, valid_o=1, multi_o=0.
  - req_i=1011 → code_o=0, multi_o=1.
  - en_i=0 with req_i=1000 → no valid.
- Backpressure, N=8: load req_i=0x10 (code 4), hold ready_i=0 for 5 cycles while req_i toggles → code_o=4 and valid_o=1 throughout. Raising ready_i with req_i=0x02 → code_o=1 on the next cycle with no bubble.
- Round robin, N=8: req_i=0xFF held, ready_i=1 → code_o sequence 0,1,2,…,7,0 on consecutive cycles, multi_o=1 each.
- Round robin wrap, N=6: grant index 5 (ptr→0), then req_i=0x21 → code 0, ptr→1. Next req_i=0x21 → code 5.
- Async reset mid-FULL: assert rst_n between edges while valid_o=1 → valid_o=0 and code_o=0 before the next edge. In RR mode the next grant with req_i=0xFF is 0.
